// File: rtl/carfield_pkg.sv
// Shared types for the dynamic Carfield address map: region entry, config field select and
// commit FSM state.
package carfield_pkg;

    // Storage width of a region entry; narrower instances use the low bits.
    localparam int unsigned RegionAddrWidth = 64;
    localparam int unsigned RegionPortWidth = 8;

    typedef struct packed {
        logic [RegionAddrWidth-1:0] base;
        logic [RegionAddrWidth-1:0] size;
        logic [RegionPortWidth-1:0] port;
        logic                       en;
    } region_t;

    typedef enum logic [1:0] {
        FieldBase = 2'd0,
        FieldSize = 2'd1,
        FieldCtrl = 2'd2,
        FieldRsvd = 2'd3
    } cfg_field_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StApply = 2'd2
    } commit_state_e;

endpackage

// File: rtl/carfield_addr_region_match.sv
// Single address-region comparator: base <= addr < base + size, with the limit held one bit
// wider so a region running past the top of the address space never wraps onto low addresses.
module carfield_addr_region_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] size_i,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 match_o
);

    logic [AddrWidth:0] limit;

    always_comb begin
        limit   = {1'b0, base_i} + {1'b0, size_i};
        match_o = en_i && (size_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < limit);
    end

endmodule

// File: rtl/carfield_addr_map_dyn.sv
// Dynamically reconfigurable address map: cfg writes a shadow table, commit drains outstanding
// hits and then copies shadow into the active table used for lookups.
module carfield_addr_map_dyn
    import carfield_pkg::*;
#(
    parameter int unsigned NumRegions     = 8,
    parameter int unsigned NumPorts       = 8,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned DefaultPort    = 0,
    parameter logic [NumRegions-1:0][AddrWidth-1:0]       InitBase = '0,
    parameter logic [NumRegions-1:0][AddrWidth-1:0]       InitSize = '0,
    parameter logic [NumRegions-1:0][RegionPortWidth-1:0] InitPort = '0,
    parameter logic [NumRegions-1:0]                      InitEn   = '0,
    localparam int unsigned IdxWidth  = (NumRegions > 1) ? $clog2(NumRegions) : 1,
    localparam int unsigned PortWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic                 cfg_write_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_rvalid_o,
    input  logic                 commit_i,
    output logic                 commit_busy_o,
    output logic                 commit_done_o,
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    output logic                 lkp_rvalid_o,
    output logic                 lkp_hit_o,
    output logic [PortWidth-1:0] lkp_port_o,
    input  logic                 txn_done_i
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    commit_state_e        state_q, state_d;
    region_t              shadow_q [NumRegions];
    region_t              active_q [NumRegions];
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 apply;

    logic                 cfg_fire, cfg_idx_ok;
    cfg_field_e           cfg_field;
    logic [AddrWidth-1:0] cfg_rdata_d;
    logic [AddrWidth-1:0] cfg_rdata_q;
    logic                 cfg_rvalid_q;

    logic [NumRegions-1:0]      region_hit;
    logic [RegionPortWidth-1:0] hit_port;
    logic                       lkp_fire, lkp_hit_d;
    logic [PortWidth-1:0]       lkp_port_d;
    logic                       lkp_rvalid_q, lkp_hit_q;
    logic [PortWidth-1:0]       lkp_port_q;
    logic                       unused_hit_port;

    function automatic region_t init_region(int unsigned i);
        region_t r;
        r.base = RegionAddrWidth'(InitBase[i]);
        r.size = RegionAddrWidth'(InitSize[i]);
        r.port = InitPort[i];
        r.en   = InitEn[i];
        return r;
    endfunction

    // ---------------- configuration port ----------------
    assign cfg_ready_o = (state_q == StIdle);
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign cfg_idx_ok  = (32'(cfg_idx_i) < NumRegions);
    assign cfg_field   = cfg_field_e'(cfg_field_i);

    always_comb begin
        cfg_rdata_d = '0;
        if (cfg_idx_ok) begin
            case (cfg_field)
                FieldBase: cfg_rdata_d = shadow_q[cfg_idx_i].base[AddrWidth-1:0];
                FieldSize: cfg_rdata_d = shadow_q[cfg_idx_i].size[AddrWidth-1:0];
                FieldCtrl: cfg_rdata_d = AddrWidth'({shadow_q[cfg_idx_i].en,
                                                     shadow_q[cfg_idx_i].port[PortWidth-1:0]});
                default:   cfg_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegions; i++) shadow_q[i] <= init_region(i);
        end else if (cfg_fire && cfg_write_i && cfg_idx_ok) begin
            case (cfg_field)
                FieldBase: shadow_q[cfg_idx_i].base <= RegionAddrWidth'(cfg_wdata_i);
                FieldSize: shadow_q[cfg_idx_i].size <= RegionAddrWidth'(cfg_wdata_i);
                FieldCtrl: begin
                    shadow_q[cfg_idx_i].port <= RegionPortWidth'(cfg_wdata_i[PortWidth-1:0]);
                    shadow_q[cfg_idx_i].en   <= cfg_wdata_i[PortWidth];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegions; i++) active_q[i] <= init_region(i);
        end else if (apply) begin
            active_q <= shadow_q;
        end
    end

    // ---------------- lookup ----------------
    for (genvar g = 0; g < NumRegions; g++) begin : gen_match
        carfield_addr_region_match #(
            .AddrWidth(AddrWidth)
        ) u_match (
            .base_i (active_q[g].base[AddrWidth-1:0]),
            .size_i (active_q[g].size[AddrWidth-1:0]),
            .en_i   (active_q[g].en),
            .addr_i (lkp_addr_i),
            .match_o(region_hit[g])
        );
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lkp_hit_d = 1'b0;
        hit_port  = '0;
        for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                lkp_hit_d = 1'b1;
                hit_port  = active_q[i].port;
            end
        end
        lkp_port_d = lkp_hit_d ? hit_port[PortWidth-1:0] : PortWidth'(DefaultPort);
    end

    assign unused_hit_port = ^hit_port;

    assign lkp_ready_o = (state_q == StIdle) && (cnt_q != CntWidth'(MaxOutstanding));
    assign lkp_fire    = lkp_valid_i && lkp_ready_o;

    always_comb begin
        logic inc, dec;
        inc   = lkp_fire && lkp_hit_d;
        dec   = txn_done_i && (cnt_q != '0);
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    // ---------------- commit FSM ----------------
    always_comb begin
        state_d       = state_q;
        commit_busy_o = 1'b0;
        commit_done_o = 1'b0;
        apply         = 1'b0;
        case (state_q)
            StIdle: begin
                if (commit_i) state_d = StDrain;
            end
            StDrain: begin
                commit_busy_o = 1'b1;
                if (cnt_q == '0) state_d = StApply;
            end
            StApply: begin
                commit_busy_o = 1'b1;
                commit_done_o = 1'b1;
                apply         = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            lkp_rvalid_q <= 1'b0;
            lkp_hit_q    <= 1'b0;
            lkp_port_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cfg_rvalid_q <= cfg_fire && !cfg_write_i;
            if (cfg_fire && !cfg_write_i) cfg_rdata_q <= cfg_rdata_d;
            lkp_rvalid_q <= lkp_fire;
            if (lkp_fire) begin
                lkp_hit_q  <= lkp_hit_d;
                lkp_port_q <= lkp_port_d;
            end
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign lkp_rvalid_o = lkp_rvalid_q;
    assign lkp_hit_o    = lkp_hit_q;
    assign lkp_port_o   = lkp_port_q;

endmodule

// File: tb/tb_carfield_addr_map_dyn.sv
// Self-checking bench for carfield_addr_map_dyn: directed scenarios plus randomized traffic
// checked against an array-based reference model of the region tables and outstanding count.
module tb_carfield_addr_map_dyn;

    localparam int unsigned NR      = 8;
    localparam int unsigned MaxOut  = 4;
    localparam int unsigned DefPort = 7;

    localparam logic [NR-1:0][63:0] TbInitBase = {{7{64'h0}}, 64'h7800_0000};
    localparam logic [NR-1:0][63:0] TbInitSize = {{7{64'h0}}, 64'h0008_0000};
    localparam logic [NR-1:0][7:0]  TbInitPort = {{7{8'h0}}, 8'h1};
    localparam logic [NR-1:0]       TbInitEn   = 8'b0000_0001;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_valid_i = 1'b0, cfg_ready_o, cfg_write_i = 1'b0;
    logic [2:0]  cfg_idx_i = '0;
    logic [1:0]  cfg_field_i = '0;
    logic [63:0] cfg_wdata_i = '0, cfg_rdata_o;
    logic        cfg_rvalid_o;
    logic        commit_i = 1'b0, commit_busy_o, commit_done_o;
    logic        lkp_valid_i = 1'b0, lkp_ready_o;
    logic [63:0] lkp_addr_i = '0;
    logic        lkp_rvalid_o, lkp_hit_o;
    logic [2:0]  lkp_port_o;
    logic        txn_done_i = 1'b0;

    carfield_addr_map_dyn #(
        .NumRegions(NR), .NumPorts(8), .AddrWidth(64), .MaxOutstanding(MaxOut),
        .DefaultPort(DefPort), .InitBase(TbInitBase), .InitSize(TbInitSize),
        .InitPort(TbInitPort), .InitEn(TbInitEn)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_write_i(cfg_write_i),
        .cfg_idx_i(cfg_idx_i), .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o), .cfg_rvalid_o(cfg_rvalid_o),
        .commit_i(commit_i), .commit_busy_o(commit_busy_o), .commit_done_o(commit_done_o),
        .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o), .lkp_addr_i(lkp_addr_i),
        .lkp_rvalid_o(lkp_rvalid_o), .lkp_hit_o(lkp_hit_o), .lkp_port_o(lkp_port_o),
        .txn_done_i(txn_done_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model
    logic [63:0] sh_base [NR], sh_size [NR], ac_base [NR], ac_size [NR];
    logic [2:0]  sh_port [NR], ac_port [NR];
    logic        sh_en [NR], ac_en [NR];
    int          outstanding;
    int          checks_n = 0, errors_n = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ctrl_word(input bit en, input logic [2:0] port);
        return {60'h0, en, port};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            sh_base[i] = TbInitBase[i];
            sh_size[i] = TbInitSize[i];
            sh_port[i] = TbInitPort[i][2:0];
            sh_en[i]   = TbInitEn[i];
        end
        model_apply();
        outstanding = 0;
    endtask

    task automatic model_apply();
        for (int i = 0; i < NR; i++) begin
            ac_base[i] = sh_base[i];
            ac_size[i] = sh_size[i];
            ac_port[i] = sh_port[i];
            ac_en[i]   = sh_en[i];
        end
    endtask

    function automatic void model_lookup(input logic [63:0] addr, output logic hit,
                                         output logic [2:0] port);
        hit  = 1'b0;
        port = 3'(DefPort);
        for (int i = 0; i < NR; i++) begin
            if (!hit && ac_en[i] && ac_size[i] != 0 && addr >= ac_base[i] &&
                (addr - ac_base[i]) < ac_size[i]) begin
                hit  = 1'b1;
                port = ac_port[i];
            end
        end
    endfunction

    task automatic cfg_write(input int idx, input int field, input logic [63:0] data);
        check_eq("cfg_ready_wr", cfg_ready_o, 1'b1);
        cfg_valid_i = 1'b1; cfg_write_i = 1'b1; cfg_idx_i = 3'(idx);
        cfg_field_i = 2'(field); cfg_wdata_i = data;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0; cfg_write_i = 1'b0;
        case (field)
            0: sh_base[idx] = data;
            1: sh_size[idx] = data;
            2: begin sh_en[idx] = data[3]; sh_port[idx] = data[2:0]; end
            default: ;
        endcase
    endtask

    task automatic cfg_read(input int idx, input int field);
        logic [63:0] exp;
        case (field)
            0: exp = sh_base[idx];
            1: exp = sh_size[idx];
            2: exp = ctrl_word(sh_en[idx], sh_port[idx]);
            default: exp = 64'h0;
        endcase
        cfg_valid_i = 1'b1; cfg_write_i = 1'b0; cfg_idx_i = 3'(idx); cfg_field_i = 2'(field);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("cfg_rvalid", cfg_rvalid_o, 1'b1);
        check_eq($sformatf("cfg_rdata[%0d].%0d", idx, field), cfg_rdata_o, exp);
    endtask

    task automatic lookup(input logic [63:0] addr, input bit done, input bit commit);
        logic hit, acc;
        logic [2:0] port;
        acc = (outstanding != MaxOut);
        check_eq("lkp_ready", lkp_ready_o, acc);
        model_lookup(addr, hit, port);
        lkp_valid_i = 1'b1; lkp_addr_i = addr; txn_done_i = done; commit_i = commit;
        @(posedge clk_i); #1;
        lkp_valid_i = 1'b0; txn_done_i = 1'b0; commit_i = 1'b0;
        if (done && outstanding > 0) outstanding--;
        if (acc && hit) outstanding++;
        @(negedge clk_i);
        check_eq("lkp_rvalid", lkp_rvalid_o, acc);
        if (acc) begin
            check_eq($sformatf("lkp_hit@%h", addr), lkp_hit_o, hit);
            check_eq($sformatf("lkp_port@%h", addr), lkp_port_o, port);
        end
    endtask

    task automatic txn_done();
        txn_done_i = 1'b1;
        @(posedge clk_i); #1;
        txn_done_i = 1'b0;
        if (outstanding > 0) outstanding--;
    endtask

    task automatic commit_pulse();
        commit_i = 1'b1;
        @(posedge clk_i); #1;
        commit_i = 1'b0;
    endtask

    // Called while the commit is draining with nothing outstanding.
    task automatic finish_commit();
        @(negedge clk_i);
        check_eq("drain_busy", commit_busy_o, 1'b1);
        check_eq("drain_done", commit_done_o, 1'b0);
        check_eq("drain_cfg_ready", cfg_ready_o, 1'b0);
        check_eq("drain_lkp_ready", lkp_ready_o, 1'b0);
        @(negedge clk_i);
        check_eq("apply_done", commit_done_o, 1'b1);
        check_eq("apply_busy", commit_busy_o, 1'b1);
        @(negedge clk_i);
        check_eq("idle_done", commit_done_o, 1'b0);
        check_eq("idle_busy", commit_busy_o, 1'b0);
        check_eq("idle_cfg_ready", cfg_ready_o, 1'b1);
        model_apply();
    endtask

    task automatic drain_and_commit();
        while (outstanding > 0) txn_done();
        commit_pulse();
        finish_commit();
    endtask

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return {$urandom, $urandom};
        return (64'($urandom_range(0, 3)) << 28) + 64'($urandom_range(0, 32'h2400));
    endfunction

    task automatic program_random();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (k < 2) ? 3 + k : 4 + k;
            cfg_write(idx, 0, (64'($urandom_range(0, 3)) << 28) + 64'($urandom_range(0, 31)) * 64'h100);
            cfg_write(idx, 1, 64'($urandom_range(0, 32)) * 64'h100);
            cfg_write(idx, 2, ctrl_word($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7))));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        check_eq("rst_cfg_ready", cfg_ready_o, 1'b1);
        check_eq("rst_lkp_ready", lkp_ready_o, 1'b1);
        check_eq("rst_busy", commit_busy_o, 1'b0);
        check_eq("rst_done", commit_done_o, 1'b0);
        check_eq("rst_cfg_rvalid", cfg_rvalid_o, 1'b0);
        check_eq("rst_cfg_rdata", cfg_rdata_o, 64'h0);
        check_eq("rst_lkp_rvalid", lkp_rvalid_o, 1'b0);
        check_eq("rst_lkp_hit", lkp_hit_o, 1'b0);
        check_eq("rst_lkp_port", lkp_port_o, 3'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset decode at the region edges
        lookup(64'h7807_FFFF, 1'b0, 1'b0);
        check_eq("init_hit_port", lkp_port_o, 3'd1);
        lookup(64'h7808_0000, 1'b0, 1'b0);
        check_eq("init_miss_port", lkp_port_o, 3'(DefPort));
        txn_done();

        // Overlapping regions resolve to the lower index
        cfg_write(2, 0, 64'h2000_0000); cfg_write(2, 1, 64'h1000); cfg_write(2, 2, ctrl_word(1, 3));
        cfg_write(5, 0, 64'h2000_0000); cfg_write(5, 1, 64'h1000); cfg_write(5, 2, ctrl_word(1, 6));
        drain_and_commit();
        lookup(64'h2000_0800, 1'b0, 1'b0);
        check_eq("overlap_port", lkp_port_o, 3'd3);
        txn_done();

        // Shadow readback and the reserved field
        cfg_read(2, 0); cfg_read(2, 2); cfg_read(2, 3);
        cfg_write(2, 3, 64'hDEAD_BEEF);
        cfg_read(2, 0); cfg_read(2, 1); cfg_read(2, 3);

        // Staging: shadow writes stay invisible until commit
        cfg_write(0, 0, 64'h5000_0000);
        lookup(64'h5000_0000, 1'b0, 1'b0);
        check_eq("staged_miss", lkp_hit_o, 1'b0);
        drain_and_commit();
        lookup(64'h5000_0000, 1'b0, 1'b0);
        check_eq("committed_hit", lkp_hit_o, 1'b1);
        txn_done();

        // Drain: lookup alongside commit_i uses the old table and is counted
        cfg_write(2, 2, ctrl_word(0, 3));
        lookup(64'h2000_0000, 1'b0, 1'b0);
        lookup(64'h2000_0010, 1'b0, 1'b0);
        lookup(64'h2000_0800, 1'b0, 1'b1);
        check_eq("commit_same_cycle_port", lkp_port_o, 3'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("drain_wait_busy", commit_busy_o, 1'b1);
            check_eq("drain_wait_lkp_ready", lkp_ready_o, 1'b0);
            check_eq("drain_wait_done", commit_done_o, 1'b0);
            txn_done();
        end
        finish_commit();
        lookup(64'h2000_0800, 1'b0, 1'b0);
        check_eq("after_disable_port", lkp_port_o, 3'd6);
        txn_done();

        // Saturation and simultaneous hit/done
        for (int i = 0; i < 4; i++) lookup(64'h2000_0000 + 64'(i), 1'b0, 1'b0);
        @(negedge clk_i);
        check_eq("sat_lkp_ready", lkp_ready_o, 1'b0);
        lookup(64'h2000_0000, 1'b0, 1'b0);
        txn_done();
        lookup(64'h2000_0004, 1'b1, 1'b0);
        lookup(64'h2000_0008, 1'b0, 1'b0);
        check_eq("sat_again_lkp_ready", lkp_ready_o, 1'b0);

        // Region spanning the top of the address space
        cfg_write(1, 0, 64'hFFFF_FFFF_FFFF_F000);
        cfg_write(1, 1, 64'h2000);
        cfg_write(1, 2, ctrl_word(1, 2));
        drain_and_commit();
        lookup(64'h0, 1'b0, 1'b0);
        check_eq("wrap_miss", lkp_hit_o, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        check_eq("wrap_top_port", lkp_port_o, 3'd2);

        // Randomized traffic
        program_random();
        drain_and_commit();
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 11);
            if (it == 150) begin
                program_random();
                drain_and_commit();
            end
            if (r < 6)       lookup(rand_addr(), 1'b0, 1'b0);
            else if (r < 8)  lookup(rand_addr(), 1'b1, 1'b0);
            else if (r < 10) txn_done();
            else             cfg_read($urandom_range(0, NR - 1), $urandom_range(0, 3));
        end

        // Reset in the middle of a commit abandons it
        while (outstanding > 0) txn_done();
        lookup(64'h5000_0000, 1'b0, 1'b0);
        commit_pulse();
        @(negedge clk_i);
        check_eq("pre_rst_busy", commit_busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        model_reset();
        check_eq("mid_rst_busy", commit_busy_o, 1'b0);
        check_eq("mid_rst_cfg_ready", cfg_ready_o, 1'b1);
        check_eq("mid_rst_lkp_ready", lkp_ready_o, 1'b1);
        check_eq("mid_rst_lkp_rvalid", lkp_rvalid_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        cfg_read(0, 0);
        lookup(64'h7807_FFFF, 1'b0, 1'b0);
        check_eq("post_rst_port", lkp_port_o, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
